// File: rtl/lsu.sv
// Load/store stage: passes ALU results through, runs a single req/gnt/rvalid
// data-bus access per memory op, with byte-lane steering and load extension.
module lsu #(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_rd_reg_en,
    input  logic [4:0]  ex_rd_reg_addr,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_inst,
    output logic [31:0] lsu_reg_wdata_o,
    output logic        lsu_rd_reg_en_o,
    output logic [4:0]  lsu_rd_reg_addr_o,
    output logic [31:0] lsu_pc_o,
    output logic [31:0] lsu_inst_o,
    output logic        lsu_stall_o,
    output logic        lsu_misalign_o,
    output logic        lsu_bus_err_o,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] ldata_q, ldata_d;
    logic [31:0] tmo_q, tmo_d;
    logic        err_q, err_d;

    logic        mem_op, size_ok, misalign, legal, timeout;
    logic        req_c, stall_c;
    logic [1:0]  off;
    logic [31:0] rshift, ext;

    assign off      = ex_alu_result[1:0];
    assign mem_op   = ex_valid & (ex_mem_rd | ex_mem_wr);
    assign misalign = ((ex_funct3[1:0] == 2'b01) & off[0]) |
                      ((ex_funct3[1:0] == 2'b10) & (off != 2'b00));
    assign legal    = mem_op & size_ok & ~misalign;
    assign timeout  = (BUS_TIMEOUT != 0) && (tmo_q == BUS_TIMEOUT - 1);

    always_comb begin
        size_ok = 1'b0;
        if (ex_mem_rd) begin
            case (ex_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_ok = 1'b1;
                default:                                size_ok = 1'b0;
            endcase
        end else begin
            case (ex_funct3)
                3'b000, 3'b001, 3'b010: size_ok = 1'b1;
                default:                size_ok = 1'b0;
            endcase
        end
    end

    assign rshift = dbus_rdata >> {off, 3'b000};

    always_comb begin
        case (ex_funct3)
            3'b000:  ext = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  ext = {{16{rshift[15]}}, rshift[15:0]};
            3'b100:  ext = {24'h000000, rshift[7:0]};
            3'b101:  ext = {16'h0000, rshift[15:0]};
            default: ext = dbus_rdata;
        endcase
    end

    // Bus payload comes straight from ex_*, which the stall holds steady.
    assign dbus_we   = ex_mem_wr & ~ex_mem_rd;
    assign dbus_addr = {ex_alu_result[31:2], 2'b00};

    always_comb begin
        dbus_be    = 4'b1111;
        dbus_wdata = ex_store_data;
        if (dbus_we) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    dbus_be    = 4'b0001 << off;
                    dbus_wdata = {4{ex_store_data[7:0]}};
                end
                2'b01: begin
                    dbus_be    = 4'b0011 << off;
                    dbus_wdata = {2{ex_store_data[15:0]}};
                end
                default: begin
                    dbus_be    = 4'b1111;
                    dbus_wdata = ex_store_data;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ldata_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ldata_q <= ldata_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ldata_d = ldata_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal) begin
                    tmo_d   = '0;
                    state_d = dbus_gnt ? WAIT : REQ;
                end
            end
            REQ: begin
                tmo_d = tmo_q + 32'd1;
                if (dbus_gnt) begin
                    state_d = WAIT;
                end else if (timeout) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            WAIT: begin
                tmo_d = tmo_q + 32'd1;
                if (dbus_rvalid) begin
                    ldata_d = ext;
                    state_d = DONE;
                end else if (timeout) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_c           = 1'b0;
        stall_c         = 1'b0;
        lsu_misalign_o  = 1'b0;
        lsu_reg_wdata_o = ex_alu_result;
        lsu_rd_reg_en_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                end else if (mem_op) begin
                    lsu_misalign_o = 1'b1;
                end else begin
                    lsu_rd_reg_en_o = ex_valid & ex_rd_reg_en;
                end
            end
            REQ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
            end
            WAIT: stall_c = 1'b1;
            default: begin
                if (ex_mem_rd) begin
                    lsu_reg_wdata_o = ldata_q;
                    lsu_rd_reg_en_o = ex_rd_reg_en & ~err_q;
                end
            end
        endcase
    end

    // IDLE still sees the frozen ex_* op during reset; gate so nothing escapes.
    assign dbus_req      = req_c & rst_n;
    assign lsu_stall_o   = stall_c & rst_n;
    assign lsu_bus_err_o = err_q;

    assign lsu_pc_o          = ex_pc;
    assign lsu_inst_o        = ex_inst;
    assign lsu_rd_reg_addr_o = ex_rd_reg_addr;

endmodule
